// File: rtl/uart_mem_dumper_if.sv
// Debug read port between the UART memory dumper (master) and the data RAM (slave).
// Read data appears two rising edges after the mem_req cycle.
interface uart_mem_dumper_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) ();
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_data
  );
endinterface

// File: rtl/uart_mem_dumper.sv
// Streams a contiguous range of data-RAM words out over an 8N1 UART, LSB byte first.
// o_busy keeps the pipeline stalled and the RAM under debug ownership for the whole dump.
module uart_mem_dumper #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH:0]   i_word_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_uart_tx,
  uart_mem_dumper_if.master     mem_bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_CAPTURE,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [DATA_WIDTH-1:0] r_word;
  logic [7:0]            r_shift;
  logic [BAUD_W-1:0]     r_baud;
  logic [2:0]            r_bit;
  logic [1:0]            r_byte_idx;

  logic                  w_bit_end;
  logic [ADDR_WIDTH:0]   w_remaining_dec;

  assign w_bit_end       = (r_baud == BAUD_LAST);
  assign w_remaining_dec = r_remaining - (ADDR_WIDTH+1)'(1);

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_uart_tx        = r_tx;
  assign mem_bus.mem_req  = r_mem_req;
  assign mem_bus.mem_addr = r_addr;

  // Every output is a register set on the transition into its state, so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_word      <= '0;
      r_shift     <= '0;
      r_baud      <= '0;
      r_bit       <= '0;
      r_byte_idx  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads pre-edge register values.
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr      <= i_start_addr;
            r_remaining <= i_word_count;
            r_busy      <= 1'b1;
            if (i_word_count == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_mem_req <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          r_mem_req <= 1'b0;
          r_state   <= S_WAIT;
        end

        S_WAIT: r_state <= S_CAPTURE;

        S_CAPTURE: begin
          r_word     <= mem_bus.mem_data;
          r_shift    <= mem_bus.mem_data[7:0];
          r_byte_idx <= '0;
          r_baud     <= '0;
          r_tx       <= 1'b0;
          r_state    <= S_START_BIT;
        end

        S_START_BIT: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA_BITS;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        S_DATA_BITS: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP_BIT;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        S_STOP_BIT: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_byte_idx != 2'd3) begin
              // Back-to-back frames: the next start bit follows the stop bit directly.
              r_byte_idx <= r_byte_idx + 2'd1;
              r_word     <= r_word >> 8;
              r_shift    <= r_word[15:8];
              r_tx       <= 1'b0;
              r_state    <= S_START_BIT;
            end else begin
              r_state <= S_NEXT;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        S_NEXT: begin
          r_remaining <= w_remaining_dec;
          r_addr      <= r_addr + ADDR_WIDTH'(1);
          if (w_remaining_dec != '0) begin
            r_mem_req <= 1'b1;
            r_state   <= S_FETCH;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dumper.sv
// Directed bench for uart_mem_dumper at CLKS_PER_BIT=4 (40-cycle byte frames).
// A bench-side UART receiver and a 2-cycle-latency RAM model supply all expectations.
module tb_uart_mem_dumper;

  localparam int CPB = 4;
  localparam int AW  = 14;
  localparam int DW  = 32;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic [AW-1:0] i_start_addr;
  logic [AW:0]   i_word_count;
  logic          o_busy;
  logic          o_done;
  logic          o_uart_tx;

  uart_mem_dumper_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  uart_mem_dumper #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_start_addr(i_start_addr),
    .i_word_count(i_word_count),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_uart_tx   (o_uart_tx),
    .mem_bus     (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [AW-1:0] a);
    case (a)
      14'h0005: return 32'h1234_5678;
      14'h3FFF: return 32'hAABB_CCDD;
      14'h0000: return 32'h0102_0304;
      14'h0002: return 32'hCAFE_F00D;
      14'h0010: return 32'h1122_3344;
      14'h0011: return 32'h5566_7788;
      14'h0100: return 32'hDEAD_BEEF;
      default:  return 32'h0BAD_F00D;
    endcase
  endfunction

  // RAM model: data valid only in the cycle after the 2nd edge following mem_req.
  logic [31:0] rd_stage;
  logic        req_d1;
  always @(posedge clk) begin
    req_d1 <= mem_if.mem_req;
    if (mem_if.mem_req) rd_stage <= mem_model(mem_if.mem_addr);
    mem_if.mem_data <= req_d1 ? rd_stage : 32'hBAD0_BAD0;
  end

  logic [31:0] q_addr[$];
  int          q_cyc[$];
  int          tx_low_cnt = 0;
  int          done_cnt   = 0;
  always @(negedge clk) begin
    if (mem_if.mem_req === 1'b1) begin
      q_addr.push_back(32'(mem_if.mem_addr));
      q_cyc.push_back(cyc);
    end
    if (o_uart_tx === 1'b0) tx_low_cnt++;
    if (o_done === 1'b1) done_cnt++;
  end

  task automatic do_start(input logic [AW-1:0] addr, input logic [AW:0] cnt);
    @(negedge clk);
    i_start      = 1'b1;
    i_start_addr = addr;
    i_word_count = cnt;
    @(negedge clk);
    i_start      = 1'b0;
  endtask

  task automatic rx_byte(output logic [7:0] b, output int start_cyc);
    int n;
    b = '0;
    start_cyc = -1;
    n = 0;
    @(negedge clk);
    while (o_uart_tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      check("rx_timeout", 32'd1, 32'd0);
      return;
    end
    start_cyc = cyc;
    repeat (CPB/2) @(negedge clk);
    check("start_bit", 32'(o_uart_tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = o_uart_tx;
    end
    repeat (CPB) @(negedge clk);
    check("stop_bit", 32'(o_uart_tx), 32'd1);
  endtask

  task automatic rx_word(input logic [31:0] w, input string tag,
                         output int first_cyc, output int last_cyc);
    logic [7:0] b;
    int         sc;
    int         prev;
    prev = 0;
    first_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      rx_byte(b, sc);
      check(tag, 32'(b), 32'(w[8*i +: 8]));
      if (i == 0) first_cyc = sc;
      else        check("byte_gap", sc - prev, 10*CPB);
      prev = sc;
    end
    last_cyc = prev;
  endtask

  task automatic wait_done(input int budget, output int done_at);
    int n;
    n = 0;
    done_at = -1;
    while (o_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("done_timeout", 32'd1, 32'd0);
    else             done_at = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int f1, l1, f2, l2, dcyc, sc, n;

    rst          = 1'b1;
    i_start      = 1'b0;
    i_start_addr = '0;
    i_word_count = '0;
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(o_uart_tx),       32'd1);
    check("rst_busy", 32'(o_busy),          32'd0);
    check("rst_done", 32'(o_done),          32'd0);
    check("rst_req",  32'(mem_if.mem_req),  32'd0);
    check("rst_addr", 32'(mem_if.mem_addr), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single word at 0x0005
    q_addr.delete(); q_cyc.delete(); done_cnt = 0;
    do_start(14'h0005, 15'd1);
    check("busy_after_start", 32'(o_busy), 32'd1);
    rx_word(32'h1234_5678, "w5_byte", f1, l1);
    check("w5_first_byte_lat", f1 - ((q_cyc.size() > 0) ? q_cyc[0] : 0), 3);
    wait_done(60, dcyc);
    check("w5_busy_in_done", 32'(o_busy), 32'd1);
    check("w5_done_lat", dcyc - ((q_cyc.size() > 0) ? q_cyc[0] : 0), 3 + 40*CPB + 1);
    @(negedge clk);
    check("w5_busy_fall", 32'(o_busy), 32'd0);
    check("w5_done_fall", 32'(o_done), 32'd0);
    repeat (4) @(negedge clk);
    check("w5_done_cnt", done_cnt, 1);
    check("w5_req_cnt",  q_addr.size(), 1);
    check("w5_req_addr", (q_addr.size() > 0) ? q_addr[0] : 32'hFFFF_FFFF, 32'h0005);

    // Address wrap 0x3FFF -> 0x0000
    q_addr.delete(); q_cyc.delete(); done_cnt = 0;
    do_start(14'h3FFF, 15'd2);
    rx_word(32'hAABB_CCDD, "wrap0_byte", f1, l1);
    rx_word(32'h0102_0304, "wrap1_byte", f2, l2);
    check("wrap_word_gap", f2 - l1, 10*CPB + 4);
    wait_done(60, dcyc);
    check("wrap_done_lat", dcyc - l2, 10*CPB + 1);
    repeat (4) @(negedge clk);
    check("wrap_req_cnt",   q_addr.size(), 2);
    check("wrap_req_addr0", (q_addr.size() > 0) ? q_addr[0] : 32'hFFFF_FFFF, 32'h3FFF);
    check("wrap_req_addr1", (q_addr.size() > 1) ? q_addr[1] : 32'hFFFF_FFFF, 32'h0000);
    check("wrap_done_cnt",  done_cnt, 1);

    // Zero word count
    q_addr.delete(); q_cyc.delete(); done_cnt = 0; tx_low_cnt = 0;
    do_start(14'h0020, 15'd0);
    check("zero_busy", 32'(o_busy), 32'd1);
    check("zero_done", 32'(o_done), 32'd1);
    @(negedge clk);
    check("zero_busy_fall", 32'(o_busy), 32'd0);
    check("zero_done_fall", 32'(o_done), 32'd0);
    repeat (8) @(negedge clk);
    check("zero_req_cnt", q_addr.size(), 0);
    check("zero_tx_low",  tx_low_cnt, 0);
    check("zero_done_cnt", done_cnt, 1);

    // Start pulse during the 2nd byte must be ignored
    q_addr.delete(); q_cyc.delete(); done_cnt = 0;
    do_start(14'h0010, 15'd2);
    fork
      begin
        repeat (60) @(negedge clk);
        i_start      = 1'b1;
        i_start_addr = 14'h0100;
        i_word_count = 15'd1;
        @(negedge clk);
        i_start      = 1'b0;
      end
    join_none
    rx_word(32'h1122_3344, "busy0_byte", f1, l1);
    rx_word(32'h5566_7788, "busy1_byte", f2, l2);
    check("busy_word_gap", f2 - l1, 10*CPB + 4);
    wait_done(60, dcyc);
    repeat (20) @(negedge clk);
    check("busy_req_cnt",   q_addr.size(), 2);
    check("busy_req_addr0", (q_addr.size() > 0) ? q_addr[0] : 32'hFFFF_FFFF, 32'h0010);
    check("busy_req_addr1", (q_addr.size() > 1) ? q_addr[1] : 32'hFFFF_FFFF, 32'h0011);
    check("busy_done_cnt",  done_cnt, 1);
    check("busy_idle",      32'(o_busy), 32'd0);

    // Asynchronous reset in the middle of byte 1's data bits
    q_addr.delete(); q_cyc.delete(); done_cnt = 0;
    do_start(14'h0005, 15'd1);
    rx_byte(b, sc);
    check("mid_byte0", 32'(b), 32'h78);
    n = 0;
    @(negedge clk);
    while (o_uart_tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (CPB + CPB/2) @(negedge clk);
    check("mid_pre_rst_tx", 32'(o_uart_tx), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx",   32'(o_uart_tx),       32'd1);
    check("mid_rst_busy", 32'(o_busy),          32'd0);
    check("mid_rst_done", 32'(o_done),          32'd0);
    check("mid_rst_req",  32'(mem_if.mem_req),  32'd0);
    check("mid_rst_addr", 32'(mem_if.mem_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tx_low_cnt = 0;
    repeat (50) @(negedge clk);
    check("post_rst_tx_quiet", tx_low_cnt, 0);
    check("post_rst_busy",     32'(o_busy), 32'd0);
    q_addr.delete(); q_cyc.delete(); done_cnt = 0;
    do_start(14'h0002, 15'd1);
    rx_word(32'hCAFE_F00D, "post_rst_byte", f1, l1);
    wait_done(60, dcyc);
    repeat (4) @(negedge clk);
    check("post_rst_req_cnt",  q_addr.size(), 1);
    check("post_rst_req_addr", (q_addr.size() > 0) ? q_addr[0] : 32'hFFFF_FFFF, 32'h0002);
    check("post_rst_done_cnt", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
